// File: rtl/led_ctrl_pkg.sv
// led_ctrl_pkg: mode/state types and perceptual brightness table for led_pattern_ctrl
package led_ctrl_pkg;
    typedef enum logic [1:0] {STATIC, BLINK, CHASE, COUNT} mode_t;
    typedef enum logic [1:0] {OFF, ARMED, RUN} state_t;
    localparam logic [3:0] GAMMA_LUT [16] = '{
        4'd0, 4'd0, 4'd1, 4'd1, 4'd1, 4'd2, 4'd2, 4'd3,
        4'd4, 4'd5, 4'd6, 4'd7, 4'd9, 4'd11, 4'd13, 4'd15
    };
endpackage

// File: rtl/led_prescaler.sv
// led_prescaler: divides clk by DIV into a one-cycle tick on the last count
module led_prescaler #(
    parameter int DIV = 4
) (
    input  logic clk,
    input  logic rstn,
    output logic tick
);
    localparam int W = (DIV > 2) ? $clog2(DIV) : 1;
    logic [W-1:0] cnt;
    if (DIV < 2) begin : g_div_chk
        $error("led_prescaler: DIV must be >= 2");
    end
    assign tick = cnt == W'(DIV - 1);
    always_ff @(posedge clk or negedge rstn)
        if (!rstn) cnt <= '0;
        else       cnt <= tick ? '0 : cnt + W'(1);
endmodule

// File: rtl/led_pattern_ctrl.sv
// led_pattern_ctrl: tick-synchronous LED pattern sequencer with PWM dimming; LED_GAMMA_EN selects gamma-corrected brightness
import led_ctrl_pkg::*;
module led_pattern_ctrl #(
    parameter int CLK_HZ   = 12000000,
    parameter int TICK_HZ  = 8,
    parameter int NLEDS    = 5,
    parameter int PWM_BITS = 4
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [1:0]          cmd_mode,
    input  logic [PWM_BITS-1:0] cmd_level,
    output logic                busy,
    output logic                tick,
    output logic [NLEDS-1:0]    led
);
    localparam int DIV = CLK_HZ / TICK_HZ;
    state_t              state, state_nx;
    mode_t               mode, mode_nx, pend_mode;
    logic [PWM_BITS-1:0] level, level_nx, pend_level, pwm_cnt, level_eff;
    logic [NLEDS-1:0]    pattern, pattern_nx, init_pat, step_pat;
    logic                accept, pwm_on;

    led_prescaler #(.DIV(DIV)) u_prescaler (.clk(clk), .rstn(rstn), .tick(tick));

`ifdef LED_GAMMA_EN
    if (PWM_BITS != 4) begin : g_gamma_chk
        $error("led_pattern_ctrl: LED_GAMMA_EN requires PWM_BITS == 4");
    end
    assign level_eff = GAMMA_LUT[level];
`else
    assign level_eff = level;
`endif

    assign cmd_ready = state != ARMED;
    assign busy      = state == ARMED;
    assign accept    = cmd_valid && cmd_ready;
    assign pwm_on    = pwm_cnt < level_eff;

    always_comb begin
        init_pat = (pend_mode == CHASE) ? NLEDS'(1) : (pend_mode == COUNT) ? '0 : '1;
        step_pat = (mode == BLINK) ? ~pattern :
                   (mode == CHASE) ? {pattern[NLEDS-2:0], pattern[NLEDS-1]} :
                   (mode == COUNT) ? pattern + NLEDS'(1) : pattern;
    end

    // an accept on a RUN tick still lets the old pattern advance before arming
    always_comb begin
        state_nx   = state;
        mode_nx    = mode;
        level_nx   = level;
        pattern_nx = pattern;
        if (state == ARMED && tick) begin
            mode_nx    = pend_mode;
            level_nx   = pend_level;
            state_nx   = (pend_level == '0) ? OFF : RUN;
            pattern_nx = (pend_level == '0) ? '0 : init_pat;
        end else if (state == RUN && tick) begin
            pattern_nx = step_pat;
        end
        if (accept) state_nx = ARMED;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state      <= OFF;
            mode       <= STATIC;
            level      <= '0;
            pattern    <= '0;
            pend_mode  <= STATIC;
            pend_level <= '0;
            pwm_cnt    <= '0;
            led        <= '0;
        end else begin
            state   <= state_nx;
            mode    <= mode_nx;
            level   <= level_nx;
            pattern <= pattern_nx;
            pwm_cnt <= pwm_cnt + PWM_BITS'(1);
            led     <= pattern & {NLEDS{pwm_on}};
            if (accept) begin
                pend_mode  <= mode_t'(cmd_mode);
                pend_level <= cmd_level;
            end
        end
    end
endmodule

// File: tb/tb_led_pattern_ctrl.sv
// tb_led_pattern_ctrl: directed stimulus checked against a cycle model of the sequencer plus literal expectations
module tb_led_pattern_ctrl;
    localparam int DIV = 4;
    logic       clk = 0, rstn = 1, cmd_valid = 0;
    logic [1:0] cmd_mode = 0;
    logic [3:0] cmd_level = 0;
    logic       cmd_ready, busy, tick;
    logic [4:0] led;
    int checks = 0, fails = 0;
    bit run = 0;
    int cyc = 0, ms = 0, pm = 0, pl = 0, mm = 0, ml = 0, pat = 0, mled = 0, tk, acc;

    led_pattern_ctrl #(.CLK_HZ(16), .TICK_HZ(4), .NLEDS(5), .PWM_BITS(4)) dut (
        .clk(clk), .rstn(rstn), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_mode(cmd_mode), .cmd_level(cmd_level), .busy(busy), .tick(tick), .led(led)
    );

    always #5 clk = ~clk;

    task automatic chk(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int pat_init(int m);
        return (m == 2) ? 1 : (m == 3) ? 0 : 31;
    endfunction

    function automatic int pat_step(int m, int p);
        case (m)
            1:       return 31 - p;
            2:       return ((p * 2) % 32) + (p / 16);
            3:       return (p + 1) % 32;
            default: return p;
        endcase
    endfunction

    // model: ms 0=off 1=waiting for tick 2=running; cyc counts edges since reset release
    always @(posedge clk) begin
        if (!rstn) begin
            cyc = 0; ms = 0; pm = 0; pl = 0; mm = 0; ml = 0; pat = 0; mled = 0;
        end else begin
            tk   = int'(cyc % DIV == DIV - 1);
            acc  = int'(cmd_valid && ms != 1);
            mled = ((cyc % 16) < ml) ? pat : 0;
            if (ms == 1 && tk != 0) begin
                mm  = pm;
                ml  = pl;
                pat = (pl == 0) ? 0 : pat_init(pm);
                ms  = (pl == 0) ? 0 : 2;
            end else if (ms == 2 && tk != 0) begin
                pat = pat_step(mm, pat);
            end
            if (acc != 0) begin
                pm = int'(cmd_mode);
                pl = int'(cmd_level);
                ms = 1;
            end
            cyc++;
        end
    end

    always @(negedge clk) if (run) begin
        chk("model_led",   int'(led),       rstn ? mled : 0);
        chk("model_busy",  int'(busy),      rstn ? int'(ms == 1) : 0);
        chk("model_ready", int'(cmd_ready), rstn ? int'(ms != 1) : 1);
        chk("model_tick",  int'(tick),      rstn ? int'(cyc % DIV == DIV - 1) : 0);
    end

    task automatic send(int m, int l);
        int n = 0;
        @(posedge clk); #1;
        cmd_valid = 1; cmd_mode = 2'(m); cmd_level = 4'(l);
        @(negedge clk);
        while (!cmd_ready && n < 20) begin @(negedge clk); n++; end
        chk("send_ready", int'(cmd_ready), 1);
        @(posedge clk); #1;
        cmd_valid = 0;
    endtask

    task automatic wait_tick();
        int n = 0;
        @(negedge clk);
        while (!tick && n < 3 * DIV) begin @(negedge clk); n++; end
        chk("tick_seen", int'(tick), 1);
    endtask

    task automatic or_led(int n, output int v);
        v = 0;
        repeat (n) begin @(negedge clk); v = v | int'(led); end
    endtask

    task automatic count_on(int n, output int c);
        c = 0;
        repeat (n) begin @(negedge clk); c = c + int'(led != 0); end
    endtask

    initial begin
        logic [12:0] exp_tick;
        int chase_exp [6];
        int v, n;
        exp_tick  = 13'b0100010001000;
        chase_exp = '{1, 2, 4, 8, 16, 1};
        #3 rstn = 0; run = 1;
        #1;
        chk("rst_led", int'(led), 0);
        chk("rst_ready", int'(cmd_ready), 1);
        chk("rst_busy", int'(busy), 0);
        chk("rst_tick", int'(tick), 0);
        @(posedge clk); #1 rstn = 1;
        for (int k = 0; k < 13; k++) begin
            @(negedge clk);
            chk("idle_tick", int'(tick), int'(exp_tick[k]));
        end
        or_led(27, v);
        chk("idle_led", v, 0);

        send(2, 15);
        @(negedge clk);
        chk("armed_busy", int'(busy), 1);
        chk("armed_ready", int'(cmd_ready), 0);
        if (!tick) wait_tick();
        @(negedge clk);
        for (int i = 0; i < 6; i++) begin
            or_led(3, v);
            chk("chase_pat", v, chase_exp[i]);
            @(negedge clk);
        end
        count_on(16, n);
        chk("chase_duty", n, 15);

        send(3, 8);
        @(negedge clk);
        if (!tick) wait_tick();
        repeat (34) @(negedge clk);
        count_on(16, n);
        chk("count_duty", n, 8);
        repeat (100) @(negedge clk);

        send(1, 15);
        @(negedge clk);
        if (!tick) wait_tick();
        wait_tick();
        #1;
        cmd_valid = 1; cmd_mode = 2'(0); cmd_level = 4'(15);
        @(posedge clk); #1 cmd_valid = 0;
        @(negedge clk);
        chk("blink_acc_busy", int'(busy), 1);
        repeat (3) @(negedge clk);
        chk("blink_hold_ready", int'(cmd_ready), 0);
        chk("blink_hold_tick", int'(tick), 1);
        @(negedge clk);
        chk("blink_load_ready", int'(cmd_ready), 1);
        or_led(3, v);
        chk("static_pat", v, 31);

        send(0, 0);
        @(negedge clk);
        if (!tick) wait_tick();
        @(negedge clk);
        or_led(20, v);
        chk("off_led", v, 0);
        chk("off_busy", int'(busy), 0);
        chk("off_ready", int'(cmd_ready), 1);

        send(2, 15);
        @(negedge clk);
        if (!tick) wait_tick();
        repeat (6) @(negedge clk);
        @(posedge clk); #3 rstn = 0;
        #1;
        chk("async_led", int'(led), 0);
        chk("async_busy", int'(busy), 0);
        chk("async_ready", int'(cmd_ready), 1);
        @(posedge clk);
        @(posedge clk); #1 rstn = 1;
        n = 0;
        @(negedge clk);
        while (!tick && n < 20) begin @(negedge clk); n++; end
        chk("post_rst_tick", n, DIV - 1);
        repeat (10) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
